reg_bank_arbiter: RTL and testbench
===================================

Name: reg_bank_arbiter

Overview:
Round-robin arbiter and sequencer that shares one internal register bank of DEPTH x WIDTH flops between NUM_REQ requesters.
- Each requester issues single-beat read or write commands over a valid/ready handshake.
- Write data lands in the bank on the grant edge.
- Read data returns on a shared response channel one cycle after the grant, tagged with the requester index.
- Used wherever several agents (config masters, debug port) must update the same control registers without collisions.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DEPTH, 8, number of registers in the bank (power of 2)
WIDTH, 8, register data width
RESET_VAL, 0, reset value loaded into every register

Ports:
clk  input  1  single clock, all flops on posedge
reset_n  input  1  asynchronous active-low reset
req_valid  input  NUM_REQ  per-requester command valid
req_ready  output  NUM_REQ  per-requester command accepted (one-hot or zero)
req_write  input  NUM_REQ  per-requester 1=write, 0=read
req_addr  input  NUM_REQ*$clog2(DEPTH)  packed per-requester register index
req_wdata  input  NUM_REQ*WIDTH  packed per-requester write data
req_lock  input  NUM_REQ  per-requester hold-grant request (used only with lock feature)
rsp_valid  output  1  read response valid
rsp_id  output  $clog2(NUM_REQ)  requester index owning the response
rsp_rdata  output  WIDTH  read data
busy  output  1  a grant was issued this cycle

Behaviour:
- Reset, asynchronous on reset_n low:
  - all bank registers = RESET_VAL
  - rr pointer = 0
  - rsp_valid = 0, rsp_id = 0, rsp_rdata = 0, busy = 0
  - lock owner cleared
- Arbitration is combinational per cycle:
  - Candidate set = req_valid.
  - Winner = first set bit searching upward from the rr pointer, wrapping modulo NUM_REQ.
  - req_ready[winner] = 1; all other bits 0.
  - No valid requests: req_ready = 0, busy = 0.
- Transfer occurs when req_valid[i] & req_ready[i] at the clk edge.
- On a transfer:
  - The rr pointer becomes winner+1, wrapping NUM_REQ-1 -> 0.
  - Write: bank[addr] <= wdata on that edge. rsp_valid stays 0 next cycle; writes give no response.
  - Read: next cycle rsp_valid = 1, rsp_id = winner, rsp_rdata = bank[addr] sampled pre-edge. Read latency is exactly 1 cycle.
  - Response is single-cycle with no backpressure; the requester must sink it.
- rsp_valid drops to 0 in any cycle following a non-read or idle cycle.
- Throughput: one command per cycle, back-to-back allowed.
- Read-after-write to the same address on consecutive cycles returns the new value, because the write is committed before the next grant.
- Address out of range cannot occur (DEPTH is a power of 2). Index truncates to $clog2(DEPTH) bits.
- Requester dropping valid before it is granted is legal. The arbiter holds no per-requester state.
- reset_n asserted mid-operation: a pending response is discarded and any write on that edge is lost. After release, first arbitration starts at requester 0.
- Fairness: any requester holding valid is granted within NUM_REQ cycles.

Optional Feature:
Macro: REG_BANK_ARB_LOCK_EN.
- Defined:
  - When the winner transfers with req_lock[winner] = 1, it becomes lock owner.
  - While locked, only the owner may be granted and other requesters see ready = 0.
  - If the owner deasserts valid, the grant idles and the lock is held.
  - Lock releases on the first owner transfer with req_lock = 0. That transfer completes normally and the rr pointer advances past the owner.
  - Reset clears the lock.
- Undefined: req_lock is ignored, no lock flop exists, and arbitration is pure round-robin.

Decomposition:
- Shared package reg_bank_arb_pkg:
  - req_idx_t, sized $clog2(NUM_REQ)
  - addr_t, sized $clog2(DEPTH)
  - function rr_pick(valid, ptr) returning winner index and a found flag
- One natural sub-module: rr_arbiter. Combinational pick plus the rr pointer flop, reused by other shared-resource controllers.
- The bank and response pipeline stay in the top block.

Test Plan:
- Reset then idle: rsp_valid=0, req_ready=0, busy=0; read reg 3 from req0 -> rsp_rdata=RESET_VAL (0), rsp_id=0, one cycle after grant.
- req1 writes addr 2 = 8'hA5, next cycle req2 reads addr 2 -> rsp_valid=1, rsp_id=2, rsp_rdata=8'hA5.
- All four requesters valid continuously from reset -> grants 0,1,2,3,0,... exactly one ready bit per cycle.
- Pointer at 3, only req1 and req3 valid -> req3 granted first, then req1 (wrap-around).
- Assert reset_n low in the cycle after a read grant -> rsp_valid forced 0 immediately; bank returns to RESET_VAL; first post-reset grant goes to lowest valid index from 0.
- With REG_BANK_ARB_LOCK_EN: req2 transfers with lock=1 for 3 cycles while req0 is valid -> req0 ready=0 throughout. req2 issues an unlocked write -> req0 granted next cycle.

Source files
------------

// File: rtl/reg_bank_arb_pkg.sv
// reg_bank_arb_pkg
// Shared types and helpers for the register-bank arbiter and for other
// shared-resource controllers that reuse the round-robin pick.
//   DEF_*      : default sizing used by the top and by the arbiter
//   req_idx_t  : requester index for the default requester count
//   addr_t     : register index for the default bank depth
//   rr_pick    : round-robin winner search over up to MAX_REQ requesters
// Optional feature macro used elsewhere in this slice: REG_BANK_ARB_LOCK_EN
package reg_bank_arb_pkg;

  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_DEPTH   = 8;
  localparam int DEF_WIDTH   = 8;

  // The pick helper works on a fixed 8-wide view so it can serve any
  // requester count from 2 to 8; callers zero-extend their vectors.
  localparam int MAX_REQ    = 8;
  localparam int PICK_IDX_W = 3;

  typedef logic [$clog2(DEF_NUM_REQ)-1:0] req_idx_t;
  typedef logic [$clog2(DEF_DEPTH)-1:0]   addr_t;

  typedef struct packed {
    logic                  found;
    logic [PICK_IDX_W-1:0] idx;
  } pick_t;

  // Search upward from ptr, wrapping at numReq, and return the first
  // requester whose valid bit is set.
  function automatic pick_t rr_pick(input logic [MAX_REQ-1:0]    valid,
                                    input logic [PICK_IDX_W-1:0] ptr,
                                    input int unsigned           numReq);
    pick_t       res;
    int unsigned cand;
    res = '0;
    for (int unsigned k = 0; k < MAX_REQ; k++) begin
      cand = 32'(ptr) + k;
      if (cand >= numReq) cand = cand - numReq;
      if ((k < numReq) && !res.found && valid[cand[PICK_IDX_W-1:0]]) begin
        res.found = 1'b1;
        res.idx   = cand[PICK_IDX_W-1:0];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/reg_bank_arbiter_rr_arbiter.sv
// rr_arbiter
// Combinational round-robin pick plus the rotating priority pointer.
//   clk, reset_n : clock and asynchronous active-low reset
//   valid_i      : candidate requesters this cycle
//   grant_o      : one-hot grant (zero when nothing is valid)
//   winner_o     : index of the granted requester
//   found_o      : a grant is issued this cycle
// A grant always coincides with a transfer because only valid requesters
// can win, so the pointer advances on every grant.
module rr_arbiter
  import reg_bank_arb_pkg::*;
#(
  parameter  int NUM_REQ = DEF_NUM_REQ,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_REQ-1:0] valid_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [IDX_W-1:0]   winner_o,
  output logic               found_o
);

  logic [IDX_W-1:0] ptr_q, ptr_d;
  pick_t            pick;
  logic             unusedPickBits;

  // Pick a winner and compute where priority starts next cycle.
  always_comb begin
    pick     = rr_pick(MAX_REQ'(valid_i), PICK_IDX_W'(ptr_q), NUM_REQ);
    winner_o = pick.idx[IDX_W-1:0];
    found_o  = pick.found;
    grant_o  = '0;
    ptr_d    = ptr_q;
    if (pick.found) begin
      grant_o = NUM_REQ'(1) << winner_o;
      if (winner_o == IDX_W'(NUM_REQ - 1)) ptr_d = '0;
      else                                 ptr_d = winner_o + 1'b1;
    end
  end

  // Upper index bits are always zero for requester counts below 8.
  assign unusedPickBits = ^pick.idx;

  // Rotating priority pointer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) ptr_q <= '0;
    else          ptr_q <= ptr_d;
  end

endmodule

// File: rtl/reg_bank_arbiter.sv
// reg_bank_arbiter
// Shares one DEPTH x WIDTH register bank between NUM_REQ requesters using
// round-robin arbitration. Writes commit on the grant edge; reads return
// one cycle later on a shared response channel tagged with the requester.
//   clk, reset_n : clock and asynchronous active-low reset
//   req_valid/req_ready/req_write/req_addr/req_wdata/req_lock : per-requester
//                  command channel (addr/wdata packed per requester)
//   rsp_valid/rsp_id/rsp_rdata : single-cycle read response
//   busy         : a grant was issued this cycle
// Optional feature: define REG_BANK_ARB_LOCK_EN to let a requester hold the
// grant across transfers via req_lock.
module reg_bank_arbiter
  import reg_bank_arb_pkg::*;
#(
  parameter  int               NUM_REQ   = DEF_NUM_REQ,
  parameter  int               DEPTH     = DEF_DEPTH,
  parameter  int               WIDTH     = DEF_WIDTH,
  parameter  logic [WIDTH-1:0] RESET_VAL = '0,
  localparam int               IDX_W     = $clog2(NUM_REQ),
  localparam int               ADDR_W    = $clog2(DEPTH)
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*WIDTH-1:0]  req_wdata,
  input  logic [NUM_REQ-1:0]        req_lock,
  output logic                      rsp_valid,
  output logic [IDX_W-1:0]          rsp_id,
  output logic [WIDTH-1:0]          rsp_rdata,
  output logic                      busy
);

  logic [NUM_REQ-1:0] candValid;
  logic [NUM_REQ-1:0] grant;
  logic [IDX_W-1:0]   winner;
  logic               found;

  logic [ADDR_W-1:0]  selAddr;
  logic [WIDTH-1:0]   selWdata;
  logic               selWrite;

  logic [WIDTH-1:0]   bank_q [DEPTH];
  logic               rspValid_q, rspValid_d;
  logic [IDX_W-1:0]   rspId_q, rspId_d;
  logic [WIDTH-1:0]   rspRdata_q, rspRdata_d;

`ifdef REG_BANK_ARB_LOCK_EN
  logic               lockValid_q, lockValid_d;
  logic [IDX_W-1:0]   lockOwner_q, lockOwner_d;

  // While locked only the owner is a candidate; an owner transfer without
  // req_lock releases it, otherwise a locking transfer claims ownership.
  always_comb begin
    candValid   = req_valid;
    lockValid_d = lockValid_q;
    lockOwner_d = lockOwner_q;
    if (lockValid_q) candValid = req_valid & (NUM_REQ'(1) << lockOwner_q);
    if (found) begin
      if (lockValid_q) begin
        if (!req_lock[winner]) lockValid_d = 1'b0;
      end else if (req_lock[winner]) begin
        lockValid_d = 1'b1;
        lockOwner_d = winner;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lockValid_q <= 1'b0;
      lockOwner_q <= '0;
    end else begin
      lockValid_q <= lockValid_d;
      lockOwner_q <= lockOwner_d;
    end
  end
`else
  logic unusedLock;
  assign candValid  = req_valid;
  assign unusedLock = ^req_lock;
`endif

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_arbiter (
    .clk      (clk),
    .reset_n  (reset_n),
    .valid_i  (candValid),
    .grant_o  (grant),
    .winner_o (winner),
    .found_o  (found)
  );

  // Steer the winning requester's command fields.
  always_comb begin
    selAddr  = req_addr[winner*ADDR_W +: ADDR_W];
    selWdata = req_wdata[winner*WIDTH +: WIDTH];
    selWrite = req_write[winner];
  end

  // A granted read captures the pre-edge bank contents; id and data hold
  // their last value when no read is in flight.
  always_comb begin
    rspValid_d = found & ~selWrite;
    rspId_d    = rspId_q;
    rspRdata_d = rspRdata_q;
    if (rspValid_d) begin
      rspId_d    = winner;
      rspRdata_d = bank_q[selAddr];
    end
  end

  // Register bank; a granted write lands on the grant edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) bank_q[i] <= RESET_VAL;
    end else if (found && selWrite) begin
      bank_q[selAddr] <= selWdata;
    end
  end

  // Response pipeline register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rspValid_q <= 1'b0;
      rspId_q    <= '0;
      rspRdata_q <= '0;
    end else begin
      rspValid_q <= rspValid_d;
      rspId_q    <= rspId_d;
      rspRdata_q <= rspRdata_d;
    end
  end

  assign req_ready = grant;
  assign busy      = found;
  assign rsp_valid = rspValid_q;
  assign rsp_id    = rspId_q;
  assign rsp_rdata = rspRdata_q;

endmodule

// File: tb/tb_reg_bank_arbiter.sv
// tb_reg_bank_arbiter
// Drives reg_bank_arbiter with directed scenarios and random traffic and
// compares every output against a behavioural model of the bank, the
// rotating priority and the one-cycle read response.
module tb_reg_bank_arbiter;
  import reg_bank_arb_pkg::*;

  localparam int N  = 4;
  localparam int D  = 8;
  localparam int W  = 8;
  localparam int AW = 3;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    req_write = '0;
  logic [N*AW-1:0] req_addr = '0;
  logic [N*W-1:0]  req_wdata = '0;
  logic [N-1:0]    req_lock = '0;
  logic            rsp_valid;
  logic [IW-1:0]   rsp_id;
  logic [W-1:0]    rsp_rdata;
  logic            busy;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [W-1:0] mBank [D];
  int           mPtr;
  logic         expRspValid;
  req_idx_t     expRspId;
  logic [W-1:0] expRspData;
  logic         mLocked;
  int           mOwner;

  always #5 clk = ~clk;

  reg_bank_arbiter dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_lock  (req_lock),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_rdata (rsp_rdata),
    .busy      (busy)
  );

  // Single comparison point for the whole bench.
  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic checkRsp();
    checkOutput("rsp_valid", 32'(rsp_valid), 32'(expRspValid));
    if (expRspValid) begin
      checkOutput("rsp_id", 32'(rsp_id), 32'(expRspId));
      checkOutput("rsp_rdata", 32'(rsp_rdata), 32'(expRspData));
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < D; i++) mBank[i] = '0;
    mPtr        = 0;
    expRspValid = 1'b0;
    expRspId    = '0;
    expRspData  = '0;
    mLocked     = 1'b0;
    mOwner      = 0;
  endtask

  // Pulse reset for one cycle; outputs must clear as soon as it asserts.
  task automatic doReset();
    @(negedge clk);
    checkRsp();
    reset_n   = 1'b0;
    req_valid = '0;
    req_write = '0;
    req_lock  = '0;
    #1;
    checkOutput("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_ready", 32'(req_ready), 32'd0);
    checkOutput("reset_rsp_id", 32'(rsp_id), 32'd0);
    checkOutput("reset_rsp_rdata", 32'(rsp_rdata), 32'd0);
    modelReset();
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  // One cycle: check the response of the previous cycle, drive a new
  // command set, check the grant, then advance the model past the edge.
  task automatic applyStimulus(input logic [N-1:0] v, input logic [N-1:0] w,
                               input logic [N-1:0] lk, input logic [N*AW-1:0] a,
                               input logic [N*W-1:0] d);
    int           win;
    logic [N-1:0] cand;
    int           c;
    int           ad;
    @(negedge clk);
    checkRsp();
    req_valid = v;
    req_write = w;
    req_lock  = lk;
    req_addr  = a;
    req_wdata = d;
    #1;
    cand = v;
`ifdef REG_BANK_ARB_LOCK_EN
    if (mLocked) cand = v & N'(1 << mOwner);
`endif
    win = -1;
    for (int k = 0; k < N; k++) begin
      c = (mPtr + k) % N;
      if (win < 0 && cand[c]) win = c;
    end
    checkOutput("req_ready", 32'(req_ready), (win >= 0) ? (32'd1 << win) : 32'd0);
    checkOutput("busy", 32'(busy), (win >= 0) ? 32'd1 : 32'd0);
    expRspValid = 1'b0;
    if (win >= 0) begin
      ad = int'(a[win*AW +: AW]);
      if (w[win]) begin
        mBank[ad] = d[win*W +: W];
      end else begin
        expRspValid = 1'b1;
        expRspId    = req_idx_t'(win);
        expRspData  = mBank[ad];
      end
      mPtr = (win + 1) % N;
`ifdef REG_BANK_ARB_LOCK_EN
      if (mLocked) begin
        if (!lk[win]) mLocked = 1'b0;
      end else if (lk[win]) begin
        mLocked = 1'b1;
        mOwner  = win;
      end
`endif
    end
  endtask

  function automatic logic [N*AW-1:0] oneAddr(input int req, input int ad);
    logic [N*AW-1:0] r;
    r = '0;
    r[req*AW +: AW] = AW'(ad);
    return r;
  endfunction

  function automatic logic [N*W-1:0] oneData(input int req, input logic [W-1:0] dv);
    logic [N*W-1:0] r;
    r = '0;
    r[req*W +: W] = dv;
    return r;
  endfunction

  initial begin
    modelReset();
    doReset();

    // Idle after reset, then a read of the reset value from req0.
    applyStimulus(4'b0000, 4'b0000, 4'b0000, '0, '0);
    checkOutput("idle_ready", 32'(req_ready), 32'd0);
    applyStimulus(4'b0001, 4'b0000, 4'b0000, oneAddr(0, 3), '0);
    applyStimulus(4'b0000, 4'b0000, 4'b0000, '0, '0);
    checkOutput("first_read_valid", 32'(rsp_valid), 32'd1);
    checkOutput("first_read_id", 32'(rsp_id), 32'd0);
    checkOutput("first_read_data", 32'(rsp_rdata), 32'd0);

    // req1 writes A5 to reg 2, req2 reads it back on the next cycle.
    applyStimulus(4'b0010, 4'b0010, 4'b0000, oneAddr(1, 2), oneData(1, 8'hA5));
    applyStimulus(4'b0100, 4'b0000, 4'b0000, oneAddr(2, 2), '0);
    applyStimulus(4'b0000, 4'b0000, 4'b0000, '0, '0);
    checkOutput("raw_valid", 32'(rsp_valid), 32'd1);
    checkOutput("raw_id", 32'(rsp_id), 32'd2);
    checkOutput("raw_data", 32'(rsp_rdata), 32'hA5);

    // All requesters valid from reset: strict rotation 0,1,2,3,0,...
    doReset();
    for (int i = 0; i < 8; i++) begin
      applyStimulus(4'b1111, 4'b1111, 4'b0000, oneAddr(i % N, i), oneData(i % N, W'(i)));
      checkOutput("rr_rotation", 32'(req_ready), 32'd1 << (i % N));
    end

    // Pointer at 3 with req1 and req3 valid: req3 first, then wrap to req1.
    doReset();
    applyStimulus(4'b0100, 4'b0100, 4'b0000, oneAddr(2, 0), oneData(2, 8'h11));
    applyStimulus(4'b1010, 4'b0000, 4'b0000, '0, '0);
    checkOutput("wrap_first", 32'(req_ready), 32'b1000);
    applyStimulus(4'b1010, 4'b0000, 4'b0000, '0, '0);
    checkOutput("wrap_second", 32'(req_ready), 32'b0010);

    // Reset in the cycle after a read grant discards the response and
    // restores the bank; first grant then starts from requester 0.
    applyStimulus(4'b0010, 4'b0010, 4'b0000, oneAddr(1, 2), oneData(1, 8'hA5));
    applyStimulus(4'b0001, 4'b0000, 4'b0000, oneAddr(0, 2), '0);
    doReset();
    applyStimulus(4'b1100, 4'b0000, 4'b0000, oneAddr(2, 2) | oneAddr(3, 2), '0);
    checkOutput("post_reset_grant", 32'(req_ready), 32'b0100);
    applyStimulus(4'b0000, 4'b0000, 4'b0000, '0, '0);
    checkOutput("post_reset_data", 32'(rsp_rdata), 32'd0);

`ifdef REG_BANK_ARB_LOCK_EN
    // req2 takes the lock and keeps it while req0 waits.
    doReset();
    applyStimulus(4'b0100, 4'b0000, 4'b0100, '0, '0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(4'b0101, 4'b0000, 4'b0100, '0, '0);
      checkOutput("lock_hold", 32'(req_ready), 32'b0100);
    end
    applyStimulus(4'b0101, 4'b0100, 4'b0000, oneAddr(2, 5), oneData(2, 8'h3C));
    checkOutput("lock_release", 32'(req_ready), 32'b0100);
    applyStimulus(4'b0001, 4'b0000, 4'b0000, '0, '0);
    checkOutput("after_release", 32'(req_ready), 32'b0001);
`endif

    // Random traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 59) == 0) begin
        doReset();
      end else begin
        applyStimulus(N'($urandom), N'($urandom),
                      N'($urandom) & N'($urandom) & N'($urandom),
                      (N*AW)'($urandom), (N*W)'($urandom));
      end
    end
    applyStimulus(4'b0000, 4'b0000, 4'b0000, '0, '0);
    applyStimulus(4'b0000, 4'b0000, 4'b0000, '0, '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
